// File: rtl/instr_pkg.sv
// Shared types and constants for the MIPS instruction encoder/loader:
// field formats, FSM states, field positions and opcode values.
package instr_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int OP_MSB = 31;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int SH_LSB = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // True when the declared format agrees with the opcode class.
    function automatic logic fmt_matches_op(input fmt_e fmt, input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (fmt)
            FMT_R:   ok = (op == OP_RTYPE);
            FMT_J:   ok = (op == OP_J) || (op == OP_JAL);
            FMT_I:   ok = (op != OP_RTYPE) && (op != OP_J) && (op != OP_JAL);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with power-of-two depth; head word is visible combinationally
// while not empty. Pointers carry one extra wrap bit to tell full from empty.
module word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs MIPS R/I/J fields into 32-bit words and streams them into instruction memory.
// Optional opcode/format consistency check: define ENCODER_OPCODE_CHECK_EN.
module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W:0]   Length,
    input  logic              FieldValid,
    output logic              FieldReady,
    input  logic [1:0]        Format,
    input  logic [5:0]        Upcode,
    input  logic [4:0]        Reg1,
    input  logic [4:0]        Reg2,
    input  logic [4:0]        Reg3,
    input  logic [4:0]        Shamt,
    input  logic [5:0]        Funct,
    input  logic [15:0]       Inmediate,
    input  logic [25:0]       Target,
    output logic              MemWrite,
    input  logic              MemReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    import instr_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              error_q, error_d;

    fmt_e        fmt;
    logic [31:0] enc_word;
    logic [31:0] fifo_head;
    logic        fifo_empty, fifo_full;
    logic        accept, bundle_ok, push, pop;

    assign fmt = fmt_e'(Format);

`ifdef ENCODER_OPCODE_CHECK_EN
    assign bundle_ok = (fmt != FMT_RSV) && fmt_matches_op(fmt, Upcode);
`else
    assign bundle_ok = (fmt != FMT_RSV);
`endif

    // Ready depends only on registered state so it never loops through FieldValid.
    assign FieldReady = (state_q == ST_LOAD) && !fifo_full && (cnt_q < len_q);
    assign accept     = FieldValid && FieldReady;
    assign push       = accept && bundle_ok;
    assign pop        = MemWrite && MemReady;

    assign MemWrite = !fifo_empty;
    assign MemData  = fifo_empty ? 32'h0 : fifo_head;
    assign MemAddr  = addr_q;
    assign Busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign Done     = (state_q == ST_DONE);
    assign Error    = error_q;

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        enc_word = 32'h0;
        enc_word[OP_MSB -: 6] = Upcode;
        case (fmt)
            FMT_R: begin
                enc_word[RS_LSB +: 5]   = Reg1;
                enc_word[RT_LSB +: 5]   = Reg2;
                enc_word[RD_LSB +: 5]   = Reg3;
                enc_word[SH_LSB +: 5]   = Shamt;
                enc_word[SH_LSB-1:0]    = Funct;
            end
            FMT_I: begin
                enc_word[RS_LSB +: 5]   = Reg1;
                enc_word[RT_LSB +: 5]   = Reg2;
                enc_word[RT_LSB-1:0]    = Inmediate;
            end
            FMT_J: begin
                enc_word[RS_LSB+4:0]    = Target;
            end
            default: enc_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        error_d = error_q;

        if (pop) addr_d = addr_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    len_d   = Length;
                    cnt_d   = '0;
                    addr_d  = BaseAddr;
                    error_d = 1'b0;
                    state_d = (Length == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!bundle_ok) error_d = 1'b1;
                    if ((cnt_q + 1'b1) == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            error_q <= error_d;
        end
    end

    word_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_word_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(enc_word),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder/writer side of the instruction register. It packs MIPS fields (Upcode, register specifiers, Inmediate/target) into 32-bit instruction words and streams them into instruction memory at consecutive word addresses.
- Fields are accepted through a valid/ready handshake and buffered in a 2-entry FIFO. A small FSM issues memory writes under memory backpressure.
- Used for program load at boot and for test-program injection ahead of the fetch/IR path.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- FIFO_DEPTH, 2, encoded-word buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  one-cycle pulse; begin a load session
- BaseAddr  input  ADDR_W  first write address, sampled on Start
- Length  input  ADDR_W+1  words to write, sampled on Start; 0 is legal
- FieldValid  input  1  field bundle valid
- FieldReady  output  1  encoder can accept a bundle
- Format  input  2  0=R, 1=I, 2=J, 3=reserved
- Upcode  input  6  instruction [31:26]
- Reg1  input  5  rs [25:21]
- Reg2  input  5  rt [20:16]
- Reg3  input  5  rd [15:11], R only
- Shamt  input  5  [10:6], R only
- Funct  input  6  [5:0], R only
- Inmediate  input  16  [15:0], I only
- Target  input  26  [25:0], J only
- MemWrite  output  1  write strobe
- MemReady  input  1  memory accepts the write this cycle
- MemAddr  output  ADDR_W  write word address
- MemData  output  32  encoded instruction
- Busy  output  1  session active
- Done  output  1  one-cycle pulse when the session completes
- Error  output  1  sticky; cleared on Start

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Encoding per Format:
  - R: {Upcode, Reg1, Reg2, Reg3, Shamt, Funct}
  - I: {Upcode, Reg1, Reg2, Inmediate}
  - J: {Upcode, Target}
  - Format 3: bundle is consumed, no word is written, Error=1, and the bundle still counts toward Length.
- States:
  - IDLE: Start → LOAD; Busy=1 from the next cycle. If Length=0, go to DONE instead.
  - LOAD: accept bundles while the accepted count is below Length. An accept is FieldValid&&FieldReady.
  - LOAD → DRAIN when the last bundle is accepted.
  - DRAIN → DONE when the FIFO is empty and no write is pending.
  - DONE: Done=1 for one cycle, Busy=0, → IDLE.
- FieldReady = (state==LOAD) && !fifo_full && (accepted < Length). It is combinational from registered state only; no dependence on FieldValid.
- Write latency: an accepted bundle's word reaches MemData/MemWrite no earlier than the next cycle.
- Write handshake:
  - MemWrite stays high whenever the FIFO is non-empty.
  - MemData/MemAddr stay stable while MemWrite && !MemReady.
  - A write completes on MemWrite&&MemReady; it pops the FIFO and increments MemAddr.
- Address: MemAddr starts at BaseAddr and wraps modulo 2^ADDR_W without error.
- FIFO push and pop in the same cycle leave occupancy unchanged; a push while full cannot occur because FieldReady=0.
- Throughput: 1 word/cycle with MemReady held high.
- Start while Busy is ignored.
- Reset mid-session: everything returns to reset values immediately; pending words are discarded.

Optional Feature:
- Macro ENCODER_OPCODE_CHECK_EN.
- When defined:
  - Format must be consistent with Upcode: R requires Upcode==0; J requires Upcode ∈ {2,3}; I requires any other value.
  - A mismatching bundle is dropped like Format 3 and sets Error.
- When undefined: Upcode is passed through unchecked; only Format 3 sets Error.

Decomposition:
- Shared package instr_pkg:
  - typedef enum fmt_e {FMT_R, FMT_I, FMT_J, FMT_RSV}
  - field-position localparams (OP_MSB=31, RS_LSB=21, RT_LSB=16, RD_LSB=11, SH_LSB=6)
  - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_JAL=6'h03
  - FSM state enum
- Sub-module word_fifo: synchronous FIFO with parameterised depth/width.
- The encoder mux and FSM live in the top module.

Test Plan:
- Start, BaseAddr=0x10, Length=1; I-type Upcode=0x23, Reg1=2, Reg2=5, Inmediate=0x0004, MemReady=1 → one write of 0x8C450004 at 0x10, Done pulse, Busy=0.
- R-type Reg1=1, Reg2=2, Reg3=3, Shamt=0, Funct=0x20; then J-type Upcode=2, Target=0x0000040, Length=2 → 0x00221820 @BaseAddr, 0x08000040 @BaseAddr+1.
- Length=4, MemReady=0 for 5 cycles → FieldReady drops after 2 accepts; MemData/MemAddr held stable; all 4 words are written in order once MemReady=1.
- BaseAddr=0xFF, ADDR_W=8, Length=2 → writes at 0xFF then 0x00.
- Format=3 in the middle of Length=3 → Error=1, 2 writes, Done still pulses; the next Start clears Error.
- rst_n low during LOAD with 2 words buffered → MemWrite=0 at once, no further writes, state IDLE, FieldReady=0.
